// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: multi-cycle shift-add multiply sequencer for the MUL path.
// The design has no adder of its own. Each RUN cycle it drives an external
// adder and captures that adder's sum. The result is the low WIDTH bits of
// op_a*op_b, which are the same for signed and unsigned operands.
module mul_seq_ctrl #(
  parameter int WIDTH     = 32,
  parameter int EARLY_OUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_c
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} st_t;

  st_t              state, nxt;
  logic [WIDTH-1:0] acc, mcand, mplier, res_q;
  logic [CW-1:0]    cnt;
  logic             last;

  // Next state, adder operands and handshake. Adder inputs are 0 outside RUN.
  always_comb begin
    nxt   = state;
    busy  = 1'b0;
    done  = 1'b0;
    add_a = '0;
    add_b = '0;
    last  = 1'b0;
    case (state)
      IDLE: if (start) nxt = RUN;
      RUN: begin
        busy  = 1'b1;
        add_a = acc;
        add_b = mplier[0] ? mcand : '0;
        last  = (cnt == CW'(WIDTH-1)) ||
                ((EARLY_OUT != 0) && ((mplier >> 1) == '0));
        if (last) nxt = DONE;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // State, datapath registers and the result, which is held between operations.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      res_q  <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (start) begin
          mcand  <= op_a;
          mplier <= op_b;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= add_c;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) res_q <= add_c;
        end
        default: ;
      endcase
    end
  end

  assign result = res_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb_mul_seq_ctrl: directed checks of mul_seq_ctrl in both the full-length
// variant (d0) and the early-out variant (d1). Each variant has its own
// behavioural adder.
module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic        busy0, done0, busy1, done1;
  logic [31:0] res0, res1, aa0, ab0, ac0, aa1, ab1, ac1;
  int          total = 0, bad = 0, dcnt = 0;

  always #5 clk = ~clk;

  assign ac0 = aa0 + ab0;
  assign ac1 = aa1 + ab1;

  mul_seq_ctrl #(.WIDTH(32), .EARLY_OUT(0)) d0 (
    .clk(clk), .rst(rst), .start(start0), .op_a(a0), .op_b(b0),
    .busy(busy0), .done(done0), .result(res0),
    .add_a(aa0), .add_b(ab0), .add_c(ac0));

  mul_seq_ctrl #(.WIDTH(32), .EARLY_OUT(1)) d1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(a1), .op_b(b1),
    .busy(busy1), .done(done1), .result(res1),
    .add_a(aa1), .add_b(ab1), .add_c(ac1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one cycle and observe 1 time unit after the edge. Count done
  // pulses, and check that the adder inputs are 0 outside RUN.
  task automatic tick(input bit sel);
    @(posedge clk); #1;
    if (sel ? done1 : done0) dcnt++;
    if (!(sel ? busy1 : busy0) || (sel ? done1 : done0)) begin
      chk("add_a_idle", sel ? aa1 : aa0, 32'h0);
      chk("add_b_idle", sel ? ab1 : ab0, 32'h0);
    end
  endtask

  task automatic set_in(input bit sel, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (sel) begin start1 = s; a1 = a; b1 = b; end
    else     begin start0 = s; a0 = a; b0 = b; end
  endtask

  // Issue one operation in the current cycle t, then wait for done.
  // Options: re-pulse start at t+10 (restart), or assert reset at t+12.
  task automatic run(input bit sel, input string tag, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input logic [31:0] exp,
                     input bit restart, input bit do_rst);
    int n;
    set_in(sel, 1'b1, a, b);
    tick(sel);
    set_in(sel, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D);  // late operand changes are ignored
    n = 1;
    chk({tag, "_busy1"}, {31'h0, sel ? busy1 : busy0}, 32'h1);
    while (!(sel ? done1 : done0) && n < 60) begin
      if (restart && n == 10) set_in(sel, 1'b1, 32'h11, 32'h22);
      if (restart && n == 11) set_in(sel, 1'b0, 32'h0, 32'h0);
      if (do_rst && n == 12) begin
        rst = 1'b1;
        tick(sel);
        rst = 1'b0;
        chk({tag, "_rst_busy"}, {31'h0, sel ? busy1 : busy0}, 32'h0);
        chk({tag, "_rst_done"}, {31'h0, sel ? done1 : done0}, 32'h0);
        chk({tag, "_rst_res"},  sel ? res1 : res0, 32'h0);
        return;
      end
      tick(sel);
      n++;
      if (!(sel ? done1 : done0))
        chk({tag, "_busy"}, {31'h0, sel ? busy1 : busy0}, 32'h1);
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_res"}, sel ? res1 : res0, exp);
    tick(sel);
    chk({tag, "_done_off"}, {31'h0, sel ? done1 : done0}, 32'h0);
    chk({tag, "_busy_off"}, {31'h0, sel ? busy1 : busy0}, 32'h0);
    chk({tag, "_hold"}, sel ? res1 : res0, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  {31'h0, busy0}, 32'h0);
    chk("rst_done",  {31'h0, done0}, 32'h0);
    chk("rst_res",   res0, 32'h0);
    chk("rst_add_a", aa0, 32'h0);
    chk("rst_add_b", ab0, 32'h0);
    chk("rst_res_e", res1, 32'h0);
    rst = 1'b0;
    tick(0);

    run(0, "m3x5",   32'd3,         32'd5,         33, 32'h0000000F, 0, 0);
    run(0, "mffxff", 32'hFFFFFFFF,  32'hFFFFFFFF,  33, 32'h00000001, 0, 0);
    run(0, "mwrap",  32'h80000000,  32'd2,         33, 32'h00000000, 0, 0);
    run(0, "mign",   32'd12,        32'd13,        33, 32'd156,      1, 0);
    run(0, "mrst",   32'd7,         32'd9,         33, 32'd63,       0, 1);
    run(0, "m2x2",   32'd2,         32'd2,         33, 32'd4,        0, 0);

    dcnt = 0;
    run(0, "b2b_a",  32'd6,         32'd7,         33, 32'd42,       0, 0);
    run(0, "b2b_b",  32'h0000FFFF,  32'h00010001,  33, 32'hFFFFFFFF, 0, 0);
    chk("b2b_pulses", dcnt, 2);

    run(1, "e7x1",   32'd7,         32'd1,          2, 32'd7,        0, 0);
    run(1, "e0",     32'h1234,      32'd0,          2, 32'd0,        0, 0);
    run(1, "e5x256", 32'd5,         32'h100,       10, 32'h500,      0, 0);
    run(1, "etop",   32'hFFFFFFFF,  32'h80000000,  33, 32'h80000000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
